// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage access unit for a 5-stage RV32I pipeline. It takes the EX/MEM
// register outputs (load/store control, effective address, store data) and
// runs one data-memory bus transaction at a time. It places store data and
// byte enables on the correct lanes, extracts and extends load data, and
// stalls the upstream pipeline until the access completes.
//
// Optional build macro:
//   MEM_TIMEOUT_EN - adds a response watchdog. After TIMEOUT_CYCLES cycles in
//                    REQ/WAIT without completion the access is aborted and
//                    o_bus_err pulses for one cycle. Without the macro the
//                    unit waits for the bus indefinitely and o_bus_err is 0.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_valid, i_trap        live instruction / already trapped (suppress)
//   i_mem_read/write       load / store (both set => store)
//   i_funct3               [1:0] size (byte/half/word), [2] unsigned load
//   i_addr, i_store_data   effective address, rs2 value
//   o_dmem_*               request, write enable, word address, data, mask
//   i_dmem_ready           bus accepts the request
//   i_dmem_rvalid/rdata    read response
//   o_stall                hold IF..EX/MEM
//   o_done                 one-cycle completion pulse
//   o_load_data            extended load result (held until the next load)
//   o_misaligned           one-cycle misaligned-access pulse
//   o_bus_err              one-cycle timeout pulse
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_trap,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_load_data,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  mask_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] load_data_q;
    logic        misaligned_q;

    logic        access;
    logic        misaligned;
    logic        start_ok;
    logic        latch;
    logic        capture;
    logic        timeout_hit;
    logic        err_block;
    logic [1:0]  st_off;
    logic [31:0] st_wdata;
    logic [3:0]  st_mask;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // ------------------------------------------------------------------
    // Request decode and alignment check on the live EX/MEM inputs
    // ------------------------------------------------------------------
    assign st_off     = i_addr[1:0];
    assign access     = i_valid & ~i_trap & (i_mem_read | i_mem_write);
    // Size 2'b11 is not a legal RV32I size; it is treated like a word.
    assign misaligned = ((i_funct3[1:0] == 2'b01) & st_off[0]) |
                        (i_funct3[1] & (st_off != 2'b00));
    // While a timeout pulse is out, the faulting instruction is still
    // presented upstream; it must not be restarted.
    assign start_ok   = access & ~misaligned & ~err_block;

    // Store lane placement: replicate the datum across the word so the
    // byte enables alone pick the destination lanes.
    always_comb begin
        st_wdata = i_store_data;
        st_mask  = 4'b1111;
        case (i_funct3[1:0])
            2'b00: begin
                st_wdata = {4{i_store_data[7:0]}};
                st_mask  = 4'b0001 << st_off;
            end
            2'b01: begin
                st_wdata = {2{i_store_data[15:0]}};
                st_mask  = st_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = i_store_data;
                st_mask  = 4'b1111;
            end
        endcase
    end

    // Load extraction uses the latched address/funct3, not the live inputs.
    always_comb begin
        ld_byte = i_dmem_rdata[7:0];
        case (addr_q[1:0])
            2'b00:   ld_byte = i_dmem_rdata[7:0];
            2'b01:   ld_byte = i_dmem_rdata[15:8];
            2'b10:   ld_byte = i_dmem_rdata[23:16];
            default: ld_byte = i_dmem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   ld_ext = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
            default: ld_ext = i_dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction FSM (next state and outputs)
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        o_stall    = 1'b0;
        o_dmem_req = 1'b0;
        o_done     = 1'b0;
        latch      = 1'b0;
        capture    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    latch   = 1'b1;
                    o_stall = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                o_dmem_req = 1'b1;
                o_stall    = 1'b1;
                if (i_dmem_ready) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                o_stall = 1'b1;
                if (i_dmem_rvalid) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            load_data_q  <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                addr_q   <= i_addr;
                wdata_q  <= st_wdata;
                mask_q   <= st_mask;
                we_q     <= i_mem_write;
                funct3_q <= i_funct3;
            end
            if (capture) begin
                load_data_q <= ld_ext;
            end
            // Only IDLE looks at the inputs; in every other state the
            // pipeline is stalled or already advancing past this entry.
            misaligned_q <= (state_q == S_IDLE) & access & misaligned & ~err_block;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Response watchdog
    // ------------------------------------------------------------------
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_err_q, bus_err_d;

    // cnt_q counts completed REQ/WAIT cycles; the abort edge is the one on
    // which the count reaches TIMEOUT_CYCLES.
    assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign err_block   = bus_err_q;
    assign o_bus_err   = bus_err_q;

    always_comb begin
        cnt_d = cnt_q;
        if (latch) begin
            cnt_d = '0;
        end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
        // A completion arriving in the final cycle wins over the abort.
        bus_err_d = timeout_hit &
                    (((state_q == S_REQ)  & ~i_dmem_ready) |
                     ((state_q == S_WAIT) & ~i_dmem_rvalid));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign err_block          = 1'b0;
    assign o_bus_err          = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // ------------------------------------------------------------------
    // Bus and result outputs (latched copies, stable for the whole access)
    // ------------------------------------------------------------------
    assign o_dmem_we    = o_dmem_req & we_q;
    assign o_dmem_addr  = {addr_q[31:2], 2'b00};
    assign o_dmem_wdata = wdata_q;
    assign o_dmem_mask  = mask_q;
    assign o_load_data  = load_data_q;
    assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
    localparam int MAXD = 1;
`else
    localparam int MAXD = 4;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid, i_trap, i_mem_read, i_mem_write;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_store_data;
    logic        o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_mask;
    logic        i_dmem_ready, i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_stall, o_done, o_misaligned, o_bus_err;
    logic [31:0] o_load_data;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_ld = 32'h0;

    always #5 i_clk = ~i_clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(i_valid), .i_trap(i_trap),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_store_data(i_store_data),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
        .o_dmem_mask(o_dmem_mask), .i_dmem_ready(i_dmem_ready),
        .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .o_stall(o_stall), .o_done(o_done), .o_load_data(o_load_data),
        .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
    );

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz  = f3 & 3;
        int unsigned off = a % 4;
        if (sz == 1) return (off % 2) != 0;
        if (sz >= 2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz  = f3 & 3;
        int unsigned off = a % 4;
        if (sz == 0) return 4'(1 << off);
        if (sz == 1) return 4'(3 << (off - off % 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        int unsigned sz = f3 & 3;
        if (sz == 0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        int unsigned sz  = f3 & 3;
        int unsigned off = a % 4;
        logic        uns = (f3 >= 4);
        logic [31:0] v;
        if (sz == 0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!uns && v >= 128) v = v | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = (w >> (8 * (off - off % 2))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs;
        i_valid = 0; i_trap = 0; i_mem_read = 0; i_mem_write = 0;
        i_funct3 = 0; i_addr = 0; i_store_data = 0;
        i_dmem_ready = 0; i_dmem_rvalid = 0; i_dmem_rdata = 0;
    endtask

    // One complete transaction attempt, checked cycle by cycle.
    task automatic run_txn(input string nm, input logic v, input logic tr, input logic rd,
                           input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rdw,
                           input int rdy_dly, input int rv_dly);
        logic acc, mis, go;
        int   req_cycles;
        acc = v & ~tr & (rd | wr);
        mis = ref_mis(f3, a);
        go  = acc & ~mis;
        i_valid = v; i_trap = tr; i_mem_read = rd; i_mem_write = wr;
        i_funct3 = f3; i_addr = a; i_store_data = sd;
        #1;
        total++; if (o_stall !== go) begin bad++;
            $display("FAIL %s start_stall got=%0b exp=%0b", nm, o_stall, go); end
        total++; if (o_dmem_req !== 1'b0) begin bad++;
            $display("FAIL %s start_req got=%0b exp=0", nm, o_dmem_req); end
        if (!go) begin
            tick;
            idle_inputs;
            #1;
            total++; if (o_misaligned !== (acc & mis)) begin bad++;
                $display("FAIL %s misaligned got=%0b exp=%0b", nm, o_misaligned, acc & mis); end
            total++; if ({o_dmem_req, o_stall, o_done} !== 3'b000) begin bad++;
                $display("FAIL %s noaccess req/stall/done got=%b exp=000", nm, {o_dmem_req, o_stall, o_done}); end
            tick;
            total++; if (o_misaligned !== 1'b0) begin bad++;
                $display("FAIL %s misaligned_pulse_end got=%0b exp=0", nm, o_misaligned); end
            $display("txn %s: no access (misaligned=%0b)", nm, acc & mis);
            return;
        end
        tick;
        // Upstream inputs wander during the access; the bus must not follow.
        i_valid = 0; i_addr = $urandom; i_store_data = $urandom;
        i_funct3 = 3'($urandom); i_mem_read = 1'($urandom); i_mem_write = 1'($urandom);
        req_cycles = 0;
        for (int k = 0; k <= rdy_dly; k++) begin
            i_dmem_ready  = (k == rdy_dly);
            i_dmem_rvalid = 1'($urandom);
            i_dmem_rdata  = $urandom;
            #1;
            req_cycles++;
            total++; if ({o_dmem_req, o_stall, o_done} !== 3'b110) begin bad++;
                $display("FAIL %s req_state req/stall/done got=%b exp=110", nm, {o_dmem_req, o_stall, o_done}); end
            total++; if (o_dmem_we !== wr) begin bad++;
                $display("FAIL %s we got=%0b exp=%0b", nm, o_dmem_we, wr); end
            total++; if (o_dmem_addr !== {a[31:2], 2'b00}) begin bad++;
                $display("FAIL %s addr got=%h exp=%h", nm, o_dmem_addr, {a[31:2], 2'b00}); end
            if (wr) begin
                total++; if (o_dmem_wdata !== ref_wdata(f3, sd)) begin bad++;
                    $display("FAIL %s wdata got=%h exp=%h", nm, o_dmem_wdata, ref_wdata(f3, sd)); end
                total++; if (o_dmem_mask !== ref_mask(f3, a)) begin bad++;
                    $display("FAIL %s mask got=%b exp=%b", nm, o_dmem_mask, ref_mask(f3, a)); end
            end
            tick;
        end
        if (!wr) begin
            for (int k = 0; k <= rv_dly; k++) begin
                i_dmem_rvalid = (k == rv_dly);
                i_dmem_rdata  = (k == rv_dly) ? rdw : $urandom;
                i_dmem_ready  = 1'($urandom);
                #1;
                total++; if ({o_dmem_req, o_stall, o_done} !== 3'b010) begin bad++;
                    $display("FAIL %s wait_state req/stall/done got=%b exp=010", nm, {o_dmem_req, o_stall, o_done}); end
                tick;
            end
            exp_ld = ref_load(f3, a, rdw);
        end
        i_dmem_ready = 0; i_dmem_rvalid = 1; i_dmem_rdata = $urandom;
        #1;
        total++; if ({o_dmem_req, o_stall, o_done, o_bus_err} !== 4'b0010) begin bad++;
            $display("FAIL %s done_state req/stall/done/err got=%b exp=0010", nm, {o_dmem_req, o_stall, o_done, o_bus_err}); end
        total++; if (o_load_data !== exp_ld) begin bad++;
            $display("FAIL %s load_data got=%h exp=%h", nm, o_load_data, exp_ld); end
        tick;
        idle_inputs;
        #1;
        total++; if ({o_done, o_stall, o_load_data} !== {2'b00, exp_ld}) begin bad++;
            $display("FAIL %s after_done done/stall/ld got=%b/%b/%h exp=0/0/%h", nm, o_done, o_stall, o_load_data, exp_ld); end
        $display("txn %s: %s addr=%h req_cycles=%0d ld=%h", nm, wr ? "store" : "load", a, req_cycles, o_load_data);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        i_rst_n = 0;
        idle_inputs;
        tick; tick;
        total++; if ({o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_mask,
                      o_stall, o_done, o_load_data, o_misaligned, o_bus_err} !== '0) begin bad++;
            $display("FAIL reset_outputs got=%b%b %h %h %b exp=all zero", o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_mask); end
        i_rst_n = 1;
        tick;
        total++; if ({o_dmem_req, o_stall, o_done, o_load_data} !== '0) begin bad++;
            $display("FAIL reset_release req/stall/done/ld got=%b%b%b %h exp=0", o_dmem_req, o_stall, o_done, o_load_data); end
        exp_ld = 0;
        $display("txn reset: checked");
    endtask

    task automatic test_directed;
        run_txn("sw_100",   1, 0, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0);
        run_txn("lb_203",   1, 0, 1, 0, 3'b000, 32'h203, 0, 32'h80FF1234, 0, 0);
        total++; if (o_load_data !== 32'hFFFFFF80) begin bad++;
            $display("FAIL lb_signed got=%h exp=ffffff80", o_load_data); end
        run_txn("lbu_203",  1, 0, 1, 0, 3'b100, 32'h203, 0, 32'h80FF1234, 0, 0);
        total++; if (o_load_data !== 32'h00000080) begin bad++;
            $display("FAIL lbu got=%h exp=00000080", o_load_data); end
        run_txn("sh_302",   1, 0, 0, 1, 3'b001, 32'h302, 32'h0000ABCD, 0, 0, 0);
        run_txn("lw_101",   1, 0, 1, 0, 3'b010, 32'h101, 0, 0, 0, 0);
        run_txn("trap_sw",  1, 1, 0, 1, 3'b010, 32'h100, 32'h1234, 0, 0, 0);
        run_txn("rw_both",  1, 0, 1, 1, 3'b000, 32'h401, 32'h5A, 0, 0, 0);
        run_txn("lh_u_106", 1, 0, 1, 0, 3'b101, 32'h106, 0, 32'h9876_1111, 0, 0);
    endtask

    task automatic test_slow_bus;
`ifdef MEM_TIMEOUT_EN
        run_txn("slow_lw", 1, 0, 1, 0, 3'b010, 32'h800, 0, 32'hCAFE_F00D, 1, 1);
`else
        run_txn("slow_lw", 1, 0, 1, 0, 3'b010, 32'h800, 0, 32'hCAFE_F00D, 5, 2);
`endif
    endtask

    task automatic test_reset_mid;
        i_valid = 1; i_mem_read = 1; i_funct3 = 3'b010; i_addr = 32'h40;
        tick;
        idle_inputs;
        i_dmem_ready = 1;
        tick;
        i_dmem_ready = 0;
        #1;
        total++; if (o_stall !== 1'b1) begin bad++;
            $display("FAIL rst_mid wait_stall got=%0b exp=1", o_stall); end
        i_rst_n = 0;
        #1;
        total++; if ({o_dmem_req, o_stall, o_done, o_load_data} !== '0) begin bad++;
            $display("FAIL rst_mid in_reset req/stall/done got=%b%b%b ld=%h exp=0", o_dmem_req, o_stall, o_done, o_load_data); end
        exp_ld = 0;
        tick;
        i_dmem_rvalid = 1; i_dmem_rdata = 32'hFFFF_FFFF;
        i_rst_n = 1;
        tick;
        total++; if ({o_done, o_stall, o_load_data} !== '0) begin bad++;
            $display("FAIL rst_mid after done/stall got=%b%b ld=%h exp=0", o_done, o_stall, o_load_data); end
        idle_inputs;
        $display("txn reset_mid: checked");
    endtask

    task automatic test_timeout;
        i_valid = 1; i_mem_write = 1; i_funct3 = 3'b010; i_addr = 32'h100; i_store_data = 32'h1;
        tick;
        idle_inputs;
`ifdef MEM_TIMEOUT_EN
        for (int k = 0; k < TO; k++) begin
            #1;
            total++; if ({o_dmem_req, o_stall, o_bus_err} !== 3'b110) begin bad++;
                $display("FAIL timeout req_cycle%0d req/stall/err got=%b exp=110", k, {o_dmem_req, o_stall, o_bus_err}); end
            tick;
        end
        total++; if ({o_dmem_req, o_stall, o_done, o_bus_err} !== 4'b0001) begin bad++;
            $display("FAIL timeout pulse req/stall/done/err got=%b exp=0001", {o_dmem_req, o_stall, o_done, o_bus_err}); end
        total++; if (o_load_data !== exp_ld) begin bad++;
            $display("FAIL timeout load_data got=%h exp=%h", o_load_data, exp_ld); end
        tick;
        total++; if ({o_dmem_req, o_bus_err} !== 2'b00) begin bad++;
            $display("FAIL timeout after req/err got=%b exp=00", {o_dmem_req, o_bus_err}); end
        $display("txn timeout: aborted after %0d cycles", TO);
`else
        for (int k = 0; k < 3 * TO; k++) begin
            #1;
            total++; if ({o_dmem_req, o_stall, o_bus_err} !== 3'b110) begin bad++;
                $display("FAIL no_timeout cycle%0d req/stall/err got=%b exp=110", k, {o_dmem_req, o_stall, o_bus_err}); end
            tick;
        end
        i_rst_n = 0;
        tick;
        i_rst_n = 1;
        exp_ld = 0;
        tick;
        $display("txn timeout: stall held %0d cycles", 3 * TO);
`endif
    endtask

    task automatic test_random;
        logic [2:0] f3;
        logic       rd, wr;
        int         kind;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            rd = (kind != 1);
            wr = (kind != 0);
            if (wr) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3) f3 = 3'b100;
                else if (f3 == 4) f3 = 3'b101;
            end
            run_txn($sformatf("rnd%0d", n), ($urandom % 8) != 0, ($urandom % 8) == 0, rd, wr,
                    f3, $urandom, $urandom, $urandom,
                    $urandom_range(0, MAXD), $urandom_range(0, MAXD));
        end
    endtask

    initial begin
        idle_inputs;
        i_rst_n = 0;
        test_reset;
        test_directed;
        test_slow_bus;
        test_reset_mid;
        test_timeout;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage consumer of the EX/MEM pipeline register outputs in the 5-stage RV32I core.
- Turns registered load/store control, address and store data into a single-outstanding data-memory bus transaction.
- Performs byte/halfword lane placement and load extension.
- Stalls the pipeline until the access completes, then presents load data toward MEM/WB.

Parameters:
TIMEOUT_CYCLES, 255, response watchdog limit in cycles (used only with MEM_TIMEOUT_EN)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_valid  in  1  EX/MEM slot holds a live instruction
i_trap  in  1  instruction already trapped; suppress access
i_mem_read  in  1  load
i_mem_write  in  1  store
i_funct3  in  3  [1:0] size (00 byte, 01 half, 10 word); [2] unsigned load
i_addr  in  32  effective address (EX result)
i_store_data  in  32  rs2 value
o_dmem_req  out  1  bus request
o_dmem_we  out  1  1 = write
o_dmem_addr  out  32  word-aligned address ({i_addr[31:2],2'b00})
o_dmem_wdata  out  32  lane-shifted store data
o_dmem_mask  out  4  byte enables
i_dmem_ready  in  1  bus accepts request this cycle
i_dmem_rvalid  in  1  read data valid
i_dmem_rdata  in  32  read word
o_stall  out  1  hold IF..EX/MEM this cycle
o_done  out  1  one-cycle completion pulse
o_load_data  out  32  extended load result, held until next load completes
o_misaligned  out  1  one-cycle misaligned-access pulse
o_bus_err  out  1  one-cycle timeout pulse (0 without MEM_TIMEOUT_EN)

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_dmem_req/we=0, o_dmem_addr/wdata=0, o_dmem_mask=0, o_done=0, o_load_data=0, o_misaligned=0, o_bus_err=0, timeout counter 0. o_stall=0.
- Access start: i_valid & ~i_trap & (i_mem_read|i_mem_write) in IDLE with aligned address. i_mem_read & i_mem_write both set: treat as store.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. No bus request. o_misaligned=1 for the next cycle. No stall.
- States:
  - IDLE: on start, latch addr/wdata/mask/we/funct3, go REQ. o_stall=1 combinationally in the start cycle.
  - REQ: o_dmem_req=1, bus fields stable. On i_dmem_ready: go WAIT for a load, DONE for a store. o_stall=1.
  - WAIT: o_dmem_req=0, o_stall=1. On i_dmem_rvalid: capture extracted data into o_load_data, go DONE.
  - DONE: o_done=1, o_stall=0; return to IDLE.
  - Upstream advances on the DONE cycle, so the same EX/MEM entry is never started twice.
- Store lanes:
  - Byte: wdata = {4{b}}, mask = 1<<addr[1:0].
  - Half: wdata = {2{h}}, mask = addr[1] ? 1100 : 0011.
  - Word: mask = 1111.
- Load extraction:
  - Byte selected by addr[1:0], half by addr[1].
  - Sign-extend unless funct3[2]=1.
  - Word loads ignore funct3[2].
- Minimum latency: store 3 cycles (start→REQ→DONE) with ready=1 in REQ. Load 4 cycles with rvalid the cycle after ready.
- i_dmem_rvalid outside WAIT is ignored. i_dmem_ready outside REQ is ignored.
- Inputs change during REQ/WAIT: ignored; latched copies drive the bus.
- Reset mid-transaction: immediate return to IDLE, request dropped, no o_done.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined:
  - An 8+-bit counter ($clog2(TIMEOUT_CYCLES+1)) clears on entering REQ and counts each cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES: abort to IDLE, o_dmem_req=0, o_bus_err=1 for one cycle, o_stall=0 that cycle, o_load_data unchanged, no o_done.
- Undefined: no counter; the unit waits indefinitely; o_bus_err tied 0.

Test Plan:
- Store word, addr 0x100, data 0xDEADBEEF, ready=1 in REQ → one req with we=1, addr 0x100, mask 1111, wdata 0xDEADBEEF; o_stall high 2 cycles; o_done on 3rd cycle.
- Load byte signed, addr 0x203, rdata 0x80FF1234 → mask n/a, o_load_data=0xFFFFFF80. Same with funct3=100 → 0x00000080.
- Store half, addr 0x302, data 0x0000ABCD → wdata 0xABCDABCD, mask 1100.
- Load word, addr 0x101 → no req, o_misaligned pulse, o_stall 0; i_trap=1 with valid store → no req, no pulses.
- Ready held low 5 cycles, then rvalid 3 cycles after ready → bus fields stable throughout; o_stall continuous until DONE; o_done exactly once. Reset asserted in WAIT → IDLE next edge, no o_done.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted → o_bus_err pulse after 4 cycles in REQ, return to IDLE. Without the macro → stall persists.
